// File: rtl/uncached_wbuf.sv
// Posted write buffer for uncached stores, drained as single-beat AXI writes.
// Optional feature: define WBUF_MERGE_EN to merge same-word stores into the tail entry.
module uncached_wbuf #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req,
  input  logic [1:0]  size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] req_wdata,
  output logic        addr_ok,
  output logic        data_ok,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr, tail_ptr;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] vld;
  logic [31:0]     ent_addr [DEPTH];
  logic [1:0]      ent_size [DEPTH];
  logic [3:0]      ent_strb [DEPTH];
  logic [31:0]     ent_data [DEPTH];
  logic            aw_done, w_done;
  logic            full, push, push_new, pop, merge;
  logic            unused_ok;

  assign unused_ok = ^{bid, bresp, chk_addr[1:0]};

  assign full     = (count == CW'(DEPTH));
  assign addr_ok  = req & ~full;
  assign push     = addr_ok;
  assign tail_ptr = wr_ptr - 1'b1;

`ifdef WBUF_MERGE_EN
  // The in-flight head must not change under the bus, so it is never a merge target.
  assign merge = push && vld[tail_ptr] && (ent_addr[tail_ptr][31:2] == addr[31:2]) &&
                 !((tail_ptr == rd_ptr) && (state != IDLE));
`else
  assign merge = 1'b0;
`endif

  assign push_new = push & ~merge;

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = SEND;
      SEND: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | awready) && (w_done | wready)) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      data_ok <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_ok <= push;
      count   <= count + CW'(push_new) - CW'(pop);
      if (push_new) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) vld[rd_ptr] <= 1'b0;
      if (push_new) vld[wr_ptr] <= 1'b1;
      if ((state == SEND) && (state_nxt == SEND)) begin
        aw_done <= aw_done | (awvalid & awready);
        w_done  <= w_done | (wvalid & wready);
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; vld alone says which slots are live.
  always_ff @(posedge aclk) begin
    if (push_new) begin
      ent_addr[wr_ptr] <= addr;
      ent_size[wr_ptr] <= size;
      ent_strb[wr_ptr] <= req_wstrb;
      ent_data[wr_ptr] <= req_wdata;
    end else if (merge) begin
      ent_addr[tail_ptr][1:0] <= 2'b00;
      ent_size[tail_ptr]      <= 2'd2;
      ent_strb[tail_ptr]      <= ent_strb[tail_ptr] | req_wstrb;
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ent_data[tail_ptr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_hit = chk_hit | (vld[i] & (ent_addr[i][31:2] == chk_addr[31:2]));
    end
  end

  assign empty   = (count == '0) && (state == IDLE);

  assign awaddr  = ent_addr[rd_ptr];
  assign awsize  = {1'b0, ent_size[rd_ptr]};
  assign wdata   = ent_data[rd_ptr];
  assign wstrb   = ent_strb[rd_ptr];
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_uncached_wbuf.sv
// Directed bench for uncached_wbuf; the merge scenario runs only when WBUF_MERGE_EN is defined.
module tb_uncached_wbuf;
  logic        aclk = 1'b0;
  logic        aresetn, req;
  logic [1:0]  size;
  logic [3:0]  req_wstrb;
  logic [31:0] addr, req_wdata, chk_addr;
  logic        addr_ok, data_ok, chk_hit, empty;
  logic [3:0]  awid, awcache, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_err = 0;
  int n_chk = 0;
  int n_tx;
  logic [31:0] tx_addr [8];
  logic [31:0] tx_data [8];
  logic [3:0]  tx_strb [8];
  logic [2:0]  tx_size [8];

  uncached_wbuf dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .size(size), .req_wstrb(req_wstrb),
    .addr(addr), .req_wdata(req_wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [1:0] s, input logic [3:0] st,
                     input logic [31:0] d);
    req = 1'b1; addr = a; size = s; req_wstrb = st; req_wdata = d;
  endtask

  // Lets the buffer empty itself, logging each address-phase transfer seen.
  task automatic drain(input string tag);
    int n;
    n_tx = 0;
    awready = 1'b1;
    wready  = 1'b1;
    for (n = 0; n < 200; n++) begin
      if (awvalid && awready && n_tx < 8) begin
        tx_addr[n_tx] = awaddr; tx_data[n_tx] = wdata;
        tx_strb[n_tx] = wstrb;  tx_size[n_tx] = awsize;
        n_tx++;
      end
      bvalid = bready;
      if (empty) break;
      @(negedge aclk);
    end
    bvalid = 1'b0;
    check({tag, "_drained"}, empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; req = 1'b0; size = 2'd0; req_wstrb = 4'd0; addr = '0; req_wdata = '0;
    chk_addr = '0; awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_empty", empty, 1);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_chk_hit", chk_hit, 0);
    aresetn = 1'b1;

    // word store with both channels ready
    @(negedge aclk);
    awready = 1'b1; wready = 1'b1;
    put(32'h1FAF_0000, 2'd2, 4'hF, 32'hDEAD_BEEF);
    #1 check("t1_addr_ok", addr_ok, 1);
    @(negedge aclk);
    req = 1'b0;
    check("t1_data_ok", data_ok, 1);
    check("t1_idle_awvalid", awvalid, 0);
    check("t1_not_empty", empty, 0);
    @(negedge aclk);
    check("t1_awvalid", awvalid, 1);
    check("t1_wvalid", wvalid, 1);
    check("t1_awaddr", awaddr, 32'h1FAF_0000);
    check("t1_awsize", awsize, 3'd2);
    check("t1_wdata", wdata, 32'hDEAD_BEEF);
    check("t1_wstrb", wstrb, 4'hF);
    check("t1_awid", awid, 4'd1);
    check("t1_wid", wid, 4'd1);
    check("t1_awburst", awburst, 2'b01);
    check("t1_wlast", wlast, 1);
    check("t1_data_ok_pulse", data_ok, 0);
    @(negedge aclk);
    check("t1_bready", bready, 1);
    check("t1_resp_awvalid", awvalid, 0);
    bvalid = 1'b1;
    @(negedge aclk);
    bvalid = 1'b0;
    check("t1_empty", empty, 1);
    check("t1_bready_off", bready, 0);

    // fill to DEPTH with the address channel stalled
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(32'h2000 + 32'(4 * i), 2'd2, 4'hF, 32'hA0 + 32'(i));
      #1 check("t2_addr_ok", addr_ok, 1);
      @(negedge aclk);
    end
    put(32'h2010, 2'd2, 4'hF, 32'hA4);
    awready = 1'b1; wready = 1'b1;
    #1 check("t2_full_addr_ok", addr_ok, 0);
    check("t2_head_awaddr", awaddr, 32'h2000);
    check("t2_head_awvalid", awvalid, 1);
    @(negedge aclk);
    check("t2_bready", bready, 1);
    bvalid = 1'b1;
    #1 check("t2_full_pop_addr_ok", addr_ok, 0);
    @(negedge aclk);
    bvalid = 1'b0;
    #1 check("t2_fifth_accept", addr_ok, 1);
    @(negedge aclk);
    req = 1'b0;
    check("t2_fifth_data_ok", data_ok, 1);
    drain("t2");
    check("t2_tx_count", n_tx, 4);
    for (int i = 0; i < 4; i++) check("t2_tx_addr", tx_addr[i], 32'h2004 + 32'(4 * i));

    // data channel completes three cycles before the address channel
    @(negedge aclk);
    awready = 1'b0; wready = 1'b1;
    put(32'h3000, 2'd2, 4'hF, 32'h1234_5678);
    @(negedge aclk);
    req = 1'b0;
    @(negedge aclk);
    check("t3_awvalid", awvalid, 1);
    check("t3_wvalid", wvalid, 1);
    @(negedge aclk);
    wready = 1'b0;
    check("t3_wvalid_drop", wvalid, 0);
    check("t3_awvalid_held", awvalid, 1);
    check("t3_awaddr_0", awaddr, 32'h3000);
    @(negedge aclk);
    check("t3_awaddr_1", awaddr, 32'h3000);
    check("t3_still_send", bready, 0);
    @(negedge aclk);
    check("t3_awaddr_2", awaddr, 32'h3000);
    check("t3_wdata_held", wdata, 32'h1234_5678);
    awready = 1'b1;
    @(negedge aclk);
    check("t3_bready", bready, 1);
    check("t3_awvalid_drop", awvalid, 0);
    bvalid = 1'b1;
    @(negedge aclk);
    bvalid = 1'b0;
    check("t3_single_bready", bready, 0);
    check("t3_empty", empty, 1);

    // read-path probe against a pending store
    awready = 1'b0; wready = 1'b0;
    put(32'h1FAF_0004, 2'd2, 4'hF, 32'h0BAD_F00D);
    @(negedge aclk);
    req = 1'b0;
    chk_addr = 32'h1FAF_0006;
    #1 check("t4_hit_same_word", chk_hit, 1);
    chk_addr = 32'h1FAF_0008;
    #1 check("t4_miss_next_word", chk_hit, 0);
    chk_addr = 32'h1FAF_0004;
    @(negedge aclk);
    check("t4_hit_in_flight", chk_hit, 1);
    drain("t4");
    check("t4_hit_after_drain", chk_hit, 0);

    // reset while a response is awaited with three entries held
    @(negedge aclk);
    awready = 1'b1; wready = 1'b1;
    put(32'h5000, 2'd2, 4'hF, 32'h1);
    @(negedge aclk);
    put(32'h5004, 2'd2, 4'hF, 32'h2);
    @(negedge aclk);
    put(32'h5008, 2'd2, 4'hF, 32'h3);
    @(negedge aclk);
    req = 1'b0;
    chk_addr = 32'h5008;
    check("t5_in_resp", bready, 1);
    #1 check("t5_hit_before", chk_hit, 1);
    check("t5_data_ok_before", data_ok, 1);
    #1 aresetn = 1'b0;
    #1 check("t5_awvalid", awvalid, 0);
    check("t5_wvalid", wvalid, 0);
    check("t5_bready", bready, 0);
    check("t5_empty", empty, 1);
    check("t5_chk_hit", chk_hit, 0);
    check("t5_data_ok", data_ok, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("t5_discarded_awvalid", awvalid, 0);
      check("t5_discarded_empty", empty, 1);
    end

`ifdef WBUF_MERGE_EN
    // two byte stores to one word while the head is stalled collapse into one entry
    awready = 1'b0; wready = 1'b0;
    put(32'h4000, 2'd2, 4'hF, 32'hCAFE_F00D);
    @(negedge aclk);
    put(32'h1000, 2'd0, 4'b0001, 32'h0000_0011);
    #1 check("t6_addr_ok_a", addr_ok, 1);
    @(negedge aclk);
    put(32'h1001, 2'd0, 4'b0010, 32'h0000_2200);
    #1 check("t6_addr_ok_b", addr_ok, 1);
    @(negedge aclk);
    req = 1'b0;
    check("t6_data_ok", data_ok, 1);
    drain("t6");
    check("t6_tx_count", n_tx, 2);
    check("t6_head_addr", tx_addr[0], 32'h4000);
    check("t6_merged_addr", tx_addr[1], 32'h1000);
    check("t6_merged_strb", tx_strb[1], 4'b0011);
    check("t6_merged_data", tx_data[1][15:0], 16'h2211);
    check("t6_merged_size", tx_size[1], 3'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uncached_wbuf.md
UNCACHED_WBUF -- requirements
Module: uncached_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of 2, 2..16).
REQ-002 SHALL have parameter AXI_ID, default 4'd1, value driven on awid/wid.
REQ-003 SHALL have port aclk  in  1  sole clock, rising edge.
REQ-004 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  in  1  uncached store request.
REQ-006 SHALL have port size  in  2  store size (0 byte, 1 half, 2 word).
REQ-007 SHALL have port wstrb  in  4  byte enables.
REQ-008 SHALL have port addr  in  32  physical byte address.
REQ-009 SHALL have port wdata  in  32  store data.
REQ-010 SHALL have port addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have port data_ok  out  1  posted-write completion pulse.
REQ-012 SHALL have port chk_addr  in  32  read-path probe address.
REQ-013 SHALL have port chk_hit  out  1  a buffered entry matches chk_addr[31:2].
REQ-014 SHALL have port empty  out  1  no entries, no transaction outstanding.
REQ-015 SHALL have ports awaddr/awsize/awvalid  out  32/3/1, and awready  in  1: AXI write address channel.
REQ-016 SHALL have ports awid/awlen/awburst/awlock/awcache/awprot  out  4/8/2/2/4/3: constants AXI_ID, 0, 2'b01, 0, 0, 0.
REQ-017 SHALL have ports wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1, and wready  in  1: AXI write data channel; wid=AXI_ID, wlast=1.
REQ-018 SHALL have ports bid/bresp/bvalid  in  4/2/1, and bready  out  1: AXI write response channel.

Function
REQ-019 SHALL hold entries {addr, size, wstrb, wdata} in a circular FIFO; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-020 SHALL assert addr_ok = req & ~full combinationally; enqueue on req & addr_ok.
REQ-021 SHALL pulse data_ok exactly one cycle after each accepted request.
REQ-022 SHALL, when full, keep addr_ok=0 even if a pop occurs the same cycle.
REQ-023 SHALL run an FSM IDLE->SEND->RESP->IDLE issuing the head entry as one single-beat transfer; at most one transaction outstanding.
REQ-024 SHALL in IDLE with count>0 enter SEND next cycle, asserting awvalid and wvalid together.
REQ-025 SHALL drop awvalid after awready and wvalid after wready independently; SEND->RESP once both handshakes are done, in any order or the same cycle.
REQ-026 SHALL drive bready=1 only in RESP; on bvalid pop the head and return to IDLE; bid and bresp are ignored.
REQ-027 SHALL hold awaddr/awsize/wdata/wstrb stable from SEND entry until both handshakes complete; awsize={1'b0,size}.
REQ-028 SHALL allow a push and pop in the same cycle with count unchanged.
REQ-029 SHALL compute chk_hit combinationally over all valid entries, including the head in flight.
REQ-030 SHALL assert empty = (count==0) & (state==IDLE).

Reset
REQ-031 SHALL on aresetn low immediately clear count, pointers, and all valids; force FSM to IDLE; drive awvalid, wvalid, bready, data_ok, and chk_hit to 0, and empty to 1.
REQ-032 SHALL discard buffered and in-flight writes on reset mid-transaction, with no completion.

Configuration
REQ-033 SHALL, with WBUF_MERGE_EN defined, merge a request whose addr[31:2] equals the tail entry's when that entry is not the in-flight head: OR wstrb, overwrite the enabled bytes, set size=2 and addr[1:0]=0, leave count unchanged, and still pulse data_ok.
REQ-034 SHALL, without WBUF_MERGE_EN, create one entry per accepted request.

Verification
REQ-035 SHALL cover: word store 0x1FAF_0000/0xDEADBEEF, awready=wready=1 -> awvalid and wvalid in cycle 2, bready in RESP, empty=1 after bvalid.
REQ-036 SHALL cover: 5 stores with DEPTH=4 and awready=0 -> addr_ok=0 on the 5th; the 5th is accepted the cycle after the first bvalid.
REQ-037 SHALL cover: wready 3 cycles before awready -> wvalid drops after wready, awaddr held stable, a single bready handshake.
REQ-038 SHALL cover: store to 0x1FAF_0004 pending, chk_addr=0x1FAF_0006 -> chk_hit=1; chk_addr=0x1FAF_0008 -> chk_hit=0.
REQ-039 SHALL cover: aresetn low during RESP with 3 entries -> awvalid=wvalid=bready=0 and empty=1 immediately.
REQ-040 SHALL cover, with WBUF_MERGE_EN: byte stores 0x11@0x1000 and 0x22@0x1001 while the head is blocked -> one entry, wstrb=4'b0011, wdata[15:0]=0x2211.
